period_sig_gen: RTL and testbench
=================================

// Module: period_sig_gen
// PURPOSE
//   Programmable periodic pulse source: the transmit side of the period-measurement path.
//   Generates a square/pulse train with cycle-exact period and high time on clk_i.
//   Drives the measure unit's signal input in loopback self-test and calibration sequences.
//   The measured period must equal PERIOD_I exactly.
// PARAMETERS
//   CNT_WIDTH  32  width of period_i, high_i and the internal phase counter
//   PULSE_W    16  width of pulses_i (burst length)
//   EDGE_W     32  width of edge_cnt_o
// PORTS
//   clk_i       in   1          system clock
//   arst_i      in   1          asynchronous reset, active-low
//   period_i    in   CNT_WIDTH  period in clk_i cycles; sampled only on accepted start
//   high_i      in   CNT_WIDTH  high time in cycles; sampled only on accepted start
//   pulses_i    in   PULSE_W    pulses per burst; 0 = continuous until stop
//   start_i     in   1          start request, level; acted on in IDLE only
//   stop_i      in   1          graceful stop request, level
//   sig_o       out  1          generated signal, registered, glitch-free
//   busy_o      out  1          1 while in HIGH or LOW
//   done_o      out  1          1-cycle pulse when a burst or stop completes
//   err_o       out  1          sticky: last start rejected for illegal parameters
//   edge_cnt_o  out  EDGE_W     rising edges emitted since reset; wraps modulo 2^EDGE_W
// BEHAVIOUR
//   - Reset (async, arst_i=0): state=IDLE; sig_o=0, busy_o=0, done_o=0, err_o=0, edge_cnt_o=0.
//     Takes effect immediately, including mid-pulse.
//   - Legal start: period_i>=2, 1<=high_i<period_i.
//     Illegal start in IDLE: err_o<=1, stay IDLE, sig_o stays 0.
//     A legal start clears err_o.
//   - Accepted start at edge k:
//     - period_i, high_i, pulses_i copied to shadow registers.
//     - Live inputs are ignored until the next IDLE.
//     - state<=HIGH, sig_o<=1, busy_o<=1, edge_cnt_o+=1.
//     - Latency: sig_o high visible after edge k, i.e. 1 cycle.
//   - FSM: IDLE -> HIGH -> LOW -> (HIGH | IDLE). One down-counter, reloaded at each phase entry.
//     - HIGH: exactly high cycles with sig_o=1. Then LOW, sig_o<=0.
//     - LOW: exactly period-high cycles with sig_o=0. At the end of LOW:
//       - if stop seen, or pulse count reached (pulses!=0) -> IDLE, busy_o<=0, done_o<=1 for one cycle;
//       - else -> HIGH, sig_o<=1, edge_cnt_o+=1.
//     - Rising-edge spacing is exactly period cycles. No dead cycle between periods.
//   - stop_i is graceful:
//     - latched (stop_pend) in HIGH or LOW; acted on at the end of the current LOW;
//     - the current pulse is never truncated;
//     - stop_pend clears on entry to IDLE.
//   - Emitted-pulse counter (PULSE_W bits) increments on each rising edge. Compared to the shadow
//     pulses only when shadow != 0, so continuous mode never terminates by count.
//   - Simultaneous start_i and stop_i in IDLE: stop wins, no start, no done_o.
//   - start_i while busy: ignored, shadows unchanged.
//   - start_i held high: a new burst is accepted on the first IDLE cycle after done_o.
//     That leaves a 1-cycle sig_o=0 gap beyond the period.
//   - Phase counter and comparisons are at full CNT_WIDTH; no truncation.
//     period=2^CNT_WIDTH-1 is legal.
//   - edge_cnt_o wraps from all-ones to 0 silently. No err_o on wrap.
// TESTING
//   - period=10 high=5 pulses=3, 1-cycle start -> 3 pulses, each high 5 and low 5.
//     done_o asserted 30 cycles after the start edge; busy_o falls on the same edge.
//     edge_cnt_o=3.
//   - period=2 high=1 pulses=0, then stop mid-HIGH after 7 edges -> the current period completes.
//     Rising-edge spacing is 2 throughout. Exactly one done_o; sig_o ends 0.
//   - Illegal parameters: high=0; high=period=8; period=1 -> err_o=1, sig_o=0, busy_o=0.
//     A following legal start clears err_o.
//   - Running period=12 high=3, change period_i to 5 mid-burst -> spacing stays 12 until restart.
//   - start_i and stop_i high together in IDLE -> no activity.
//     arst_i low mid-HIGH -> sig_o=0 in the same cycle and all outputs return to reset values.
//   - Loopback into the measure unit, period=1000 -> measured period reads 1000.
//     edge_cnt_o preset near wrap via a long run -> wraps to 0 with no side effects.

Source files
------------

// File: rtl/period_sig_gen_if.sv
// Bus bundle for period_sig_gen: burst parameters and controls in, generated signal and status out.
// The master is the controller side and drives period/high/pulses/start/stop.
// The slave is the generator and drives sig/busy/done/err/edge_cnt.
interface period_sig_gen_if #(
  parameter int CNT_WIDTH = 32,
  parameter int PULSE_W   = 16,
  parameter int EDGE_W    = 32
);
  logic [CNT_WIDTH-1:0] period_i;
  logic [CNT_WIDTH-1:0] high_i;
  logic [PULSE_W-1:0]   pulses_i;
  logic                 start_i;
  logic                 stop_i;
  logic                 sig_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic [EDGE_W-1:0]    edge_cnt_o;

  modport master (
    output period_i, high_i, pulses_i, start_i, stop_i,
    input  sig_o, busy_o, done_o, err_o, edge_cnt_o
  );

  modport slave (
    input  period_i, high_i, pulses_i, start_i, stop_i,
    output sig_o, busy_o, done_o, err_o, edge_cnt_o
  );
endinterface

// File: rtl/period_sig_gen.sv
// Purpose: programmable periodic pulse source with cycle-exact period/high time, bursts and graceful stop.
// Latency: sig high one cycle after the accepting start edge; rising edges exactly period cycles apart.
// Backpressure: none; start is a level acted on only in IDLE, stop waits for the end of the current LOW.
//
// Ports:
//   clk_i   system clock
//   arst_i  asynchronous reset, active-low; clears every output at once, even mid-pulse
//   bus     slave side of period_sig_gen_if:
//             period_i/high_i/pulses_i  burst parameters, shadowed on an accepted start
//             start_i/stop_i            start request (IDLE only) and graceful stop request
//             sig_o                     registered generated signal
//             busy_o/done_o/err_o       running, 1-cycle completion pulse, sticky illegal-start flag
//             edge_cnt_o                rising edges emitted since reset, wrapping
module period_sig_gen #(
  parameter int CNT_WIDTH = 32,
  parameter int PULSE_W   = 16,
  parameter int EDGE_W    = 32
) (
  input  logic               clk_i,
  input  logic               arst_i,
  period_sig_gen_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TWO = CNT_WIDTH'(2);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] sh_period;
  logic [CNT_WIDTH-1:0] sh_high;
  logic [PULSE_W-1:0]   sh_pulses;
  logic [PULSE_W-1:0]   pulse_cnt;
  logic                 stop_pend;
  logic                 sig, busy, done, err;
  logic [EDGE_W-1:0]    edge_cnt;
  logic                 sig_nxt, busy_nxt, done_nxt;

  logic legal;
  logic cnt_zero;
  logic last_pulse;
  logic start_req;

  assign legal      = (bus.period_i >= CNT_TWO) && (bus.high_i != '0) && (bus.high_i < bus.period_i);
  assign cnt_zero   = (cnt == '0);
  // A stop arriving on the final LOW cycle itself still ends the burst here.
  assign last_pulse = stop_pend || bus.stop_i || ((sh_pulses != '0) && (pulse_cnt == sh_pulses));
  // Simultaneous stop suppresses the start entirely (no start, no error update).
  assign start_req  = bus.start_i && !bus.stop_i;

  // State register plus registered outputs, so sig_o is glitch-free.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state <= IDLE;
      sig   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sig   <= sig_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_req && legal) state_nxt = HIGH;
      HIGH:    if (cnt_zero) state_nxt = LOW;
      LOW:     if (cnt_zero) state_nxt = last_pulse ? IDLE : HIGH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sig_nxt  = (state_nxt == HIGH);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == LOW) && (state_nxt == IDLE);
  end

  // Phase down-counter is loaded with (phase length - 1) on entry to each phase,
  // so a phase ends on the cycle the counter reads zero with no dead cycle.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      cnt       <= '0;
      sh_period <= '0;
      sh_high   <= '0;
      sh_pulses <= '0;
      pulse_cnt <= '0;
      stop_pend <= 1'b0;
      err       <= 1'b0;
      edge_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (start_req) begin
            if (legal) begin
              sh_period <= bus.period_i;
              sh_high   <= bus.high_i;
              sh_pulses <= bus.pulses_i;
              cnt       <= bus.high_i - CNT_ONE;
              pulse_cnt <= PULSE_W'(1);
              edge_cnt  <= edge_cnt + EDGE_W'(1);
              err       <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        HIGH: begin
          stop_pend <= stop_pend | bus.stop_i;
          cnt       <= cnt_zero ? (sh_period - sh_high - CNT_ONE) : (cnt - CNT_ONE);
        end
        LOW: begin
          if (cnt_zero && last_pulse) begin
            stop_pend <= 1'b0;
          end else begin
            stop_pend <= stop_pend | bus.stop_i;
            if (cnt_zero) begin
              cnt       <= sh_high - CNT_ONE;
              pulse_cnt <= pulse_cnt + PULSE_W'(1);
              edge_cnt  <= edge_cnt + EDGE_W'(1);
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sig_o      = sig;
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;
  assign bus.err_o      = err;
  assign bus.edge_cnt_o = edge_cnt;

endmodule

// File: tb/tb_period_sig_gen.sv
// Bench for period_sig_gen: expected output events (err changes, rising/falling sig, done) are
// derived from the burst rules with plain arithmetic and queued; a monitor matches them by cycle.
// A narrow edge counter is used so the wrap of edge_cnt_o is reached in a short run.
module tb_period_sig_gen;
  localparam int EW = 6;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  period_sig_gen_if #(.CNT_WIDTH(32), .PULSE_W(16), .EDGE_W(EW)) bus ();

  period_sig_gen #(.CNT_WIDTH(32), .PULSE_W(16), .EDGE_W(EW)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus.slave)
  );

  typedef enum int {EV_ERR, EV_RISE, EV_FALL, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       val;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;
  logic p_sig, p_err;
  int  m_edges = 0;
  bit  m_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input ev_kind_t k, input int c, input int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_t k, input int v);
    ev_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: saw %s val=%0d at cycle %0d, none expected", k.name(), v, cyc);
    end else begin
      e = q.pop_front();
      chk($sformatf("event_kind(exp %s)", e.kind.name()), k, e.kind);
      chk($sformatf("event_cycle_%s", k.name()), cyc, e.cyc);
      chk($sformatf("event_value_%s", k.name()), v, e.val);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_event: %s expected at cycle %0d, not seen by cycle %0d",
                   q[0].kind.name(), q[0].cyc, cyc);
          void'(q.pop_front());
        end
        if (bus.err_o !== p_err) expect_ev(EV_ERR, int'(bus.err_o));
        if (bus.sig_o === 1'b1 && p_sig === 1'b0) begin
          expect_ev(EV_RISE, int'(bus.edge_cnt_o));
          chk("busy_at_rise", bus.busy_o, 1);
        end
        if (bus.sig_o === 1'b0 && p_sig === 1'b1) expect_ev(EV_FALL, 0);
        if (bus.done_o === 1'b1) begin
          expect_ev(EV_DONE, 0);
          chk("busy_at_done", bus.busy_o, 0);
        end
      end
      p_sig = bus.sig_o;
      p_err = bus.err_o;
    end
  end

  // One start attempt; for legal starts the whole burst is driven while live inputs
  // and start are scrambled (they must be ignored while busy).
  // stop_off > 0 raises stop_i for the single edge c+stop_off.
  // keep=1 leaves the next call to present its start on the edge right after done.
  task automatic burst(input int p, input int h, input int n, input int stop_off, input bit keep);
    int  c, e, np, js;
    bit  legal;
    @(negedge clk);
    c = cyc + 1;
    bus.period_i = p;
    bus.high_i   = h;
    bus.pulses_i = n[15:0];
    bus.start_i  = 1'b1;
    bus.stop_i   = 1'b0;
    legal = (p >= 2) && (h >= 1) && (h < p);
    if (!legal) begin
      if (!m_err) push(EV_ERR, c, 1);
      m_err = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      return;
    end
    if (m_err) push(EV_ERR, c, 0);
    m_err = 1'b0;
    np = (n != 0) ? n : (1 << 30);
    if (stop_off > 0) begin
      js = (stop_off + p - 1) / p;
      if (js < np) np = js;
    end
    for (int j = 0; j < np; j++) begin
      push(EV_RISE, c + j * p, (m_edges + 1 + j) % (1 << EW));
      push(EV_FALL, c + j * p + h, 0);
    end
    e = c + np * p;
    push(EV_DONE, e, 0);
    m_edges += np;
    for (int t = c + 1; t <= e; t++) begin
      @(negedge clk);
      bus.start_i  = ($urandom_range(0, 3) == 0);
      bus.stop_i   = (stop_off > 0) && (t == c + stop_off);
      bus.period_i = $urandom;
      bus.high_i   = $urandom;
      bus.pulses_i = 16'($urandom);
    end
    if (!keep) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.stop_i  = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    int p, h, n, so, c;
    arst         = 1'b0;
    bus.period_i = '0;
    bus.high_i   = '0;
    bus.pulses_i = '0;
    bus.start_i  = 1'b0;
    bus.stop_i   = 1'b0;
    #2;
    chk("reset_sig", bus.sig_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_done", bus.done_o, 0);
    chk("reset_err", bus.err_o, 0);
    chk("reset_edge_cnt", bus.edge_cnt_o, 0);
    repeat (2) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // 3 pulses of 5 high / 5 low; done 30 cycles after the start edge.
    burst(10, 5, 3, 0, 0);
    chk("edge_cnt_after_first_burst", bus.edge_cnt_o, 3);

    // Continuous period 2, stop raised during the HIGH of the 7th pulse.
    burst(2, 1, 0, 13, 0);

    // Illegal parameters, then a legal start that clears err_o.
    burst(8, 0, 1, 0, 0);
    chk("illegal_sig", bus.sig_o, 0);
    chk("illegal_busy", bus.busy_o, 0);
    burst(8, 8, 1, 0, 0);
    burst(1, 1, 1, 0, 0);
    chk("illegal_err_sticky", bus.err_o, 1);
    burst(6, 2, 2, 0, 0);

    // Live period changes mid-burst are ignored.
    burst(12, 3, 3, 0, 0);

    // start and stop together in IDLE: nothing happens.
    @(negedge clk);
    bus.period_i = 4;
    bus.high_i   = 2;
    bus.pulses_i = 1;
    bus.start_i  = 1'b1;
    bus.stop_i   = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    repeat (4) @(negedge clk);
    chk("start_stop_busy", bus.busy_o, 0);

    // start held across done: next burst accepted on the first IDLE cycle.
    burst(4, 1, 2, 0, 1);
    burst(5, 2, 1, 0, 0);

    // Long period as seen by a measuring unit.
    burst(1000, 400, 3, 0, 0);

    // Long continuous run, taking edge_cnt_o through its wrap.
    burst(2, 1, 0, 90, 0);

    for (int i = 0; i < 16; i++) begin
      p = $urandom_range(2, 24);
      h = $urandom_range(1, p - 1);
      n = $urandom_range(0, 4);
      if (n == 0) so = $urandom_range(1, 3 * p);
      else so = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n * p) : 0;
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0: h = 0;
          1: h = p;
          2: h = p + 1;
          default: p = $urandom_range(0, 1);
        endcase
      end
      burst(p, h, n, so, 1'b0);
    end

    // Full-width period accepted, then async reset in the middle of HIGH.
    @(negedge clk);
    c = cyc + 1;
    bus.period_i = 32'hFFFF_FFFF;
    bus.high_i   = 32'hFFFF_FFFE;
    bus.pulses_i = '0;
    bus.start_i  = 1'b1;
    if (m_err) push(EV_ERR, c, 0);
    m_err = 1'b0;
    push(EV_RISE, c, (m_edges + 1) % (1 << EW));
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("max_period_busy", bus.busy_o, 1);
    chk("queue_drained_before_reset", q.size(), 0);
    #2;
    mon_en = 1'b0;
    arst   = 1'b0;
    #1;
    chk("async_reset_sig", bus.sig_o, 0);
    chk("async_reset_busy", bus.busy_o, 0);
    chk("async_reset_done", bus.done_o, 0);
    chk("async_reset_err", bus.err_o, 0);
    chk("async_reset_edge_cnt", bus.edge_cnt_o, 0);
    q.delete();
    m_edges = 0;
    m_err   = 1'b0;
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    burst(3, 1, 2, 0, 0);
    chk("edge_cnt_after_reset_burst", bus.edge_cnt_o, 2);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
